// File: rtl/lsu_mem_master.sv
// lsu_mem_master: MEM-stage load/store initiator for an RV32 pipeline.
// Takes one load/store at a time, drives a word-addressed memory with no
// byte enables (combinational read, write on posedge), formats load data and
// implements SB/SH as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned H/W accesses complete with rsp_err=1
//   undefined -> misaligned H/W addresses are forced aligned and proceed
module lsu_mem_master #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RMW   = 3'd2,
    S_STORE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic [2:0]      funct3_r;
  logic [AW-1:0]   idx_r;
  logic [1:0]      off_r;
  logic [31:0]     wdata_r;
  logic [31:0]     rdata_r;
  logic            err_r;

  logic            accept_s;
  logic            f3_legal_s;
  logic            misalign_s;
  logic            range_err_s;
  logic            err_s;
  logic [31:0]     aligned_addr_s;

  // Select and extend the addressed byte/halfword of a memory word.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_W:    res = word;
      F3_BU:   res = {24'h000000, b};
      F3_HU:   res = {16'h0000, h};
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  // Insert the store byte/halfword into the old word; other lanes are kept.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] new_data,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] res;
    res = old_word;
    case (f3)
      F3_B:    res[{off, 3'b000} +: 8]     = new_data[7:0];
      F3_H:    res[{off[1], 4'b0000} +: 16] = new_data[15:0];
      default: res = new_data;
    endcase
    return res;
  endfunction

  assign accept_s = req_valid & (state_r == S_IDLE);

  // Request legality: funct3 per direction, range, and alignment handling.
  always_comb begin
    f3_legal_s     = 1'b0;
    misalign_s     = 1'b0;
    aligned_addr_s = req_addr;
    range_err_s    = ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);

    if (req_we) begin
      f3_legal_s = (req_funct3 == F3_B) | (req_funct3 == F3_H) |
                   (req_funct3 == F3_W);
    end else begin
      f3_legal_s = (req_funct3 == F3_B)  | (req_funct3 == F3_H) |
                   (req_funct3 == F3_W)  | (req_funct3 == F3_BU) |
                   (req_funct3 == F3_HU);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3)
      F3_H, F3_HU: misalign_s = req_addr[0];
      F3_W:        misalign_s = (req_addr[1:0] != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
`else
    // Misaligned halfword/word addresses are silently rounded down.
    case (req_funct3)
      F3_H, F3_HU: aligned_addr_s = {req_addr[31:1], 1'b0};
      F3_W:        aligned_addr_s = {req_addr[31:2], 2'b00};
      default:     aligned_addr_s = req_addr;
    endcase
`endif

    err_s = ~f3_legal_s | misalign_s | range_err_s;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            state_s = S_RESP;
          end else if (!req_we) begin
            state_s = S_LOAD;
          end else if (req_funct3 == F3_W) begin
            state_s = S_STORE;
          end else begin
            state_s = S_RMW;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD:  state_s = S_RESP;
      S_RMW:   state_s = S_STORE;
      S_STORE: state_s = S_RESP;
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Request latch, load capture and read-modify-write merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_r <= 3'b000;
      idx_r    <= '0;
      off_r    <= 2'b00;
      wdata_r  <= 32'h00000000;
      rdata_r  <= 32'h00000000;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            funct3_r <= req_funct3;
            idx_r    <= aligned_addr_s[AW+1:2];
            off_r    <= aligned_addr_s[1:0];
            wdata_r  <= req_wdata;
            rdata_r  <= 32'h00000000;
            err_r    <= err_s;
          end
        end
        S_LOAD:  rdata_r <= fmt_load(mem_RD, funct3_r, off_r);
        S_RMW:   wdata_r <= merge_store(mem_RD, wdata_r, funct3_r, off_r);
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and latched registers only.
  always_comb begin
    req_ready = (state_r == S_IDLE);
    rsp_valid = (state_r == S_RESP);
    rsp_rdata = 32'h00000000;
    rsp_err   = 1'b0;
    mem_A     = 32'h00000000;
    mem_WD    = 32'h00000000;
    mem_WE    = 1'b0;
    case (state_r)
      S_LOAD, S_RMW: begin
        mem_A = {{(32-AW){1'b0}}, idx_r};
      end
      S_STORE: begin
        mem_A  = {{(32-AW){1'b0}}, idx_r};
        mem_WD = wdata_r;
        mem_WE = 1'b1;
      end
      S_RESP: begin
        rsp_rdata = rdata_r;
        rsp_err   = err_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a behavioural
// word memory (combinational read, write on posedge).
module tb_lsu_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  int errors = 0;
  int checks = 0;

  lsu_mem_master #(.MEM_WORDS(1024), .AW(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_RD = mem[mem_A[9:0]];

  // Memory write port; bench preloads share the same port when idle.
  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  task automatic poke(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request and observe cycles 1..6 after the accept edge.
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output int we_cnt, output int we_cyc);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rdata = 32'h0; err = 1'b0; we_cnt = 0; we_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_WE) begin we_cnt++; we_cyc = c; end
      if (rsp_valid && lat < 0) begin lat = c; rdata = rsp_rdata; err = rsp_err; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    checks++; if (mem_A !== 32'h0) begin errors++; $display("FAIL reset_mem_A: got %h expected 0", mem_A); end
    checks++; if (mem_WD !== 32'h0) begin errors++; $display("FAIL reset_mem_WD: got %h expected 0", mem_WD); end
    checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL reset_mem_WE: got %b expected 0", mem_WE); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_word;
    int lat; logic [31:0] rd; logic er; int wc; int wcy;
    poke(10'd0, 32'h00000002);
    run_req(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, er, wc, wcy);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h00000002) begin errors++; $display("FAIL lw_rdata: got %h expected 00000002", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL lw_no_write: got %0d expected 0", wc); end
  endtask

  task automatic test_load_format;
    logic [2:0]  f3s [4];
    logic [31:0] ads [4];
    logic [31:0] exs [4];
    int lat; logic [31:0] rd; logic er; int wc; int wcy;
    f3s[0] = 3'b000; ads[0] = 32'h16; exs[0] = 32'hFFFFFFFF;
    f3s[1] = 3'b100; ads[1] = 32'h16; exs[1] = 32'h000000FF;
    f3s[2] = 3'b001; ads[2] = 32'h16; exs[2] = 32'hFFFF80FF;
    f3s[3] = 3'b101; ads[3] = 32'h14; exs[3] = 32'h00007F01;
    poke(10'd5, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3s[i], ads[i], 32'h0, lat, rd, er, wc, wcy);
      checks++; if (lat !== 2) begin errors++; $display("FAIL fmt%0d_latency: got %0d expected 2", i, lat); end
      checks++; if (rd !== exs[i]) begin errors++; $display("FAIL fmt%0d_rdata: got %h expected %h", i, rd, exs[i]); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL fmt%0d_err: got %b expected 0", i, er); end
    end
  endtask

  task automatic test_store;
    int lat; logic [31:0] rd; logic er; int wc; int wcy;
    poke(10'd3, 32'h11223344);
    run_req(1'b1, 3'b000, 32'h0D, 32'hDEADBEAB, lat, rd, er, wc, wcy);
    checks++; if (wc !== 1) begin errors++; $display("FAIL sb_we_count: got %0d expected 1", wc); end
    checks++; if (wcy !== 2) begin errors++; $display("FAIL sb_we_cycle: got %0d expected 2", wcy); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_rsp: got %h/%b expected 0/0", rd, er); end
    checks++; if (mem[3] !== 32'h1122AB44) begin errors++; $display("FAIL sb_mem: got %h expected 1122AB44", mem[3]); end
    run_req(1'b1, 3'b001, 32'h0E, 32'h5566CAFE, lat, rd, er, wc, wcy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d expected 3", lat); end
    checks++; if (mem[3] !== 32'hCAFEAB44) begin errors++; $display("FAIL sh_mem: got %h expected CAFEAB44", mem[3]); end
    run_req(1'b1, 3'b010, 32'h10, 32'h13579BDF, lat, rd, er, wc, wcy);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (wcy !== 1 || wc !== 1) begin errors++; $display("FAIL sw_we: got cycle %0d count %0d expected cycle 1 count 1", wcy, wc); end
    checks++; if (mem[4] !== 32'h13579BDF) begin errors++; $display("FAIL sw_mem: got %h expected 13579BDF", mem[4]); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd; logic er; int wc; int wcy;
    run_req(1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, lat, rd, er, wc, wcy);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL oor_err: got err %b lat %0d expected 1/1", er, lat); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL oor_no_write: got %0d expected 0", wc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h expected 0", rd); end
    run_req(1'b0, 3'b011, 32'h0, 32'h0, lat, rd, er, wc, wcy);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL bad_load_f3: got err %b lat %0d expected 1/1", er, lat); end
    run_req(1'b1, 3'b100, 32'h0, 32'h0, lat, rd, er, wc, wcy);
    checks++; if (er !== 1'b1 || wc !== 0) begin errors++; $display("FAIL bad_store_f3: got err %b writes %0d expected 1/0", er, wc); end
    poke(10'd1023, 32'h0BADF00D);
    run_req(1'b0, 3'b010, 32'hFFC, 32'h0, lat, rd, er, wc, wcy);
    checks++; if (er !== 1'b0 || rd !== 32'h0BADF00D) begin errors++; $display("FAIL last_word: got %h/%b expected 0BADF00D/0", rd, er); end
  endtask

  task automatic test_misalign;
    int lat; logic [31:0] rd; logic er; int wc; int wcy;
    logic [31:0] exp_rd; logic exp_er; int exp_lat; logic [31:0] exp_m1;
    poke(10'd1, 32'hC0DE1234);
    run_req(1'b0, 3'b001, 32'h3, 32'h0, lat, rd, er, wc, wcy);
`ifdef LSU_MISALIGN_TRAP_EN
    exp_er = 1'b1; exp_lat = 1; exp_rd = 32'h0;
`else
    exp_er = 1'b0; exp_lat = 2; exp_rd = 32'h00000000;
`endif
    checks++; if (er !== exp_er || lat !== exp_lat || rd !== exp_rd) begin errors++; $display("FAIL lh_0x3: got %h/%b/%0d expected %h/%b/%0d", rd, er, lat, exp_rd, exp_er, exp_lat); end
    run_req(1'b0, 3'b001, 32'h7, 32'h0, lat, rd, er, wc, wcy);
`ifdef LSU_MISALIGN_TRAP_EN
    exp_rd = 32'h0;
`else
    exp_rd = 32'hFFFFC0DE;
`endif
    checks++; if (er !== exp_er || lat !== exp_lat || rd !== exp_rd) begin errors++; $display("FAIL lh_0x7: got %h/%b/%0d expected %h/%b/%0d", rd, er, lat, exp_rd, exp_er, exp_lat); end
    run_req(1'b1, 3'b010, 32'h6, 32'h12345678, lat, rd, er, wc, wcy);
`ifdef LSU_MISALIGN_TRAP_EN
    exp_m1 = 32'hC0DE1234;
`else
    exp_m1 = 32'h12345678;
`endif
    checks++; if (er !== exp_er || mem[1] !== exp_m1) begin errors++; $display("FAIL sw_0x6: got %h/%b expected %h/%b", mem[1], er, exp_m1, exp_er); end
  endtask

  task automatic test_back_to_back;
    logic [6:1] exp_ready; logic [6:1] exp_valid; logic [6:1] exp_we;
    logic [6:1] got_ready; logic [6:1] got_valid; logic [6:1] got_we;
    logic [31:0] lw_data;
    exp_ready = 6'b100100; exp_valid = 6'b010010; exp_we = 6'b001000;
    got_ready = '0; got_valid = '0; got_we = '0; lw_data = 32'h0;
    poke(10'd6, 32'h600DCAFE);
    poke(10'd7, 32'h00000000);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h18; req_wdata = 32'h0;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      got_ready[c] = req_ready; got_valid[c] = rsp_valid; got_we[c] = mem_WE;
      if (c == 2) lw_data = rsp_rdata;
      if (c == 1) begin
        req_we = 1'b1; req_addr = 32'h1C; req_wdata = 32'hFEEDBEEF;
      end
      if (c == 4) req_valid = 1'b0;
    end
    checks++; if (got_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready: got %b expected %b", got_ready, exp_ready); end
    checks++; if (got_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid: got %b expected %b", got_valid, exp_valid); end
    checks++; if (got_we !== exp_we) begin errors++; $display("FAIL b2b_we: got %b expected %b", got_we, exp_we); end
    checks++; if (lw_data !== 32'h600DCAFE) begin errors++; $display("FAIL b2b_lw_data: got %h expected 600DCAFE", lw_data); end
    checks++; if (mem[7] !== 32'hFEEDBEEF) begin errors++; $display("FAIL b2b_sw_mem: got %h expected FEEDBEEF", mem[7]); end
  endtask

  task automatic test_reset_mid_store;
    int lat; logic [31:0] rd; logic er; int wc; int wcy;
    poke(10'd8, 32'hA5A5A5A5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h20; req_wdata = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_WE !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b expected 1", mem_WE); end
    rst = 1'b1;
    #1;
    checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL rst_we_drop: got %b expected 0", mem_WE); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_handshake: got ready %b valid %b expected 1/0", req_ready, rsp_valid); end
    @(negedge clk);
    checks++; if (mem[8] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rst_mem_kept: got %h expected A5A5A5A5", mem[8]); end
    rst = 1'b0;
    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er, wc, wcy);
    checks++; if (rd !== 32'hA5A5A5A5 || lat !== 2) begin errors++; $display("FAIL rst_recover: got %h lat %0d expected A5A5A5A5 lat 2", rd, lat); end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    pre_we = 1'b0; pre_idx = 10'd0; pre_data = 32'h0;
    test_reset();
    test_load_word();
    test_load_format();
    test_store();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
